// File: rtl/secded_stream_decoder.sv
// Two-stage pipelined extended-Hamming SECDED decoder on a valid/ready stream with saturating error counters.
// Optional feature macro: SECDED_ERR_POS_EN adds the out_pos port (corrected bit position).
module secded_stream_decoder #(
  parameter int P_W = 4,
  parameter int CNT_W = 8,
  localparam int CODE_W = 1 << P_W,
  localparam int DATA_W = CODE_W - P_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_word,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sgl_cnt,
  output logic [CNT_W-1:0]  dbl_cnt,
  output logic              idle
`ifdef SECDED_ERR_POS_EN
  ,
  output logic [P_W-1:0]    out_pos
`endif
);

  function automatic logic [P_W-1:0] calc_syn(input logic [CODE_W-1:0] code);
    logic [P_W-1:0] syn;
    syn = '0;
    for (int i = 1; i < CODE_W; i++) begin
      syn = syn ^ (P_W'(i) & {P_W{code[i]}});
    end
    return syn;
  endfunction

  function automatic logic calc_par(input logic [CODE_W-1:0] code);
    return ^code;
  endfunction

  // Data bits occupy every non-power-of-two position above 0, packed in ascending order.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] data;
    logic              is_data;
    int                k;
    data = '0;
    k    = 0;
    for (int i = 1; i < CODE_W; i++) begin
      is_data = ((i & (i - 1)) != 0);
      data    = data | (DATA_W'(code[i] && is_data) << k);
      k       = k + (is_data ? 32'sd1 : 32'sd0);
    end
    return data;
  endfunction

  logic              s1_valid_r;
  logic [CODE_W-1:0] s1_code_r;
  logic [P_W-1:0]    s1_syn_r;
  logic              s1_par_r;
  logic              s1_load_s;
  logic              s2_load_s;
  logic              hs_s;
  logic [CODE_W-1:0] flip_s;
  logic [CODE_W-1:0] fixed_s;
  logic              sgl_s;
  logic              dbl_s;
  logic [CODE_W-1:0] word_s;

  assign s2_load_s = !out_valid || out_ready;
  assign s1_load_s = !s1_valid_r || s2_load_s;
  assign in_ready  = reset && s1_load_s;
  assign hs_s      = out_valid && out_ready;
  assign idle      = !s1_valid_r && !out_valid;

  // Stage 1: capture the codeword with its syndrome and overall parity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_code_r  <= '0;
      s1_syn_r   <= '0;
      s1_par_r   <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      s1_code_r  <= in_code;
      s1_syn_r   <= calc_syn(in_code);
      s1_par_r   <= calc_par(in_code);
    end else begin
      s1_valid_r <= s1_valid_r;
      s1_code_r  <= s1_code_r;
      s1_syn_r   <= s1_syn_r;
      s1_par_r   <= s1_par_r;
    end
  end

  // Correction: odd parity means one flipped bit at index syn (index 0 is p0 itself).
  always_comb begin
    flip_s = '0;
    if (s1_par_r) begin
      flip_s[s1_syn_r] = 1'b1;
    end else begin
      flip_s = '0;
    end
    fixed_s = s1_code_r ^ flip_s;
    sgl_s   = s1_par_r;
    dbl_s   = (s1_syn_r != '0) && !s1_par_r;
    word_s  = {dbl_s, sgl_s, {(P_W-1){1'b0}}, extract_data(fixed_s)};
  end

  // Stage 2: register the decoded word; holds while downstream stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_word  <= '0;
    end else if (s2_load_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_word <= word_s;
      end else begin
        out_word <= out_word;
      end
    end else begin
      out_valid <= out_valid;
      out_word  <= out_word;
    end
  end

`ifdef SECDED_ERR_POS_EN
  // Error position travels with out_word; only meaningful for single errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_pos <= '0;
    end else if (s2_load_s && s1_valid_r) begin
      out_pos <= s1_par_r ? s1_syn_r : '0;
    end else begin
      out_pos <= out_pos;
    end
  end
`endif

  // Saturating counters, counted on output handshake; clear wins over a same-cycle count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sgl_cnt <= '0;
      dbl_cnt <= '0;
    end else if (cnt_clr) begin
      sgl_cnt <= '0;
      dbl_cnt <= '0;
    end else begin
      if (hs_s && out_word[CODE_W-2] && (sgl_cnt != {CNT_W{1'b1}})) begin
        sgl_cnt <= sgl_cnt + CNT_W'(1);
      end else begin
        sgl_cnt <= sgl_cnt;
      end
      if (hs_s && out_word[CODE_W-1] && (dbl_cnt != {CNT_W{1'b1}})) begin
        dbl_cnt <= dbl_cnt + CNT_W'(1);
      end else begin
        dbl_cnt <= dbl_cnt;
      end
    end
  end

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Self-checking bench for secded_stream_decoder (P_W=4, CNT_W=2): directed scenarios plus randomized stream
// scored against an encode-and-search reference model.
module tb_secded_stream_decoder;
  localparam int P_W = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_code = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_word;
  logic        cnt_clr = 1'b0;
  logic [1:0]  sgl_cnt;
  logic [1:0]  dbl_cnt;
  logic        idle;
`ifdef SECDED_ERR_POS_EN
  logic [3:0]  out_pos;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;
  int m_sgl = 0;
  int m_dbl = 0;
  bit rnd_done;

  secded_stream_decoder #(.P_W(P_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .cnt_clr(cnt_clr),
    .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt), .idle(idle)
`ifdef SECDED_ERR_POS_EN
    , .out_pos(out_pos)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference code: place data, then choose each parity bit to make its covered set even.
  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] c;
    logic        a;
    int          k;
    c = 16'h0000;
    k = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      a = 1'b0;
      for (int p = 1; p < 16; p++) if (((p >> j) & 1) == 1) a = a ^ c[p];
      c[1 << j] = a;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [10:0] ext(input logic [15:0] c);
    logic [10:0] d;
    int          k;
    d = 11'h000;
    k = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p];
        k++;
      end
    end
    return d;
  endfunction

  // {pos, word}: valid codeword -> clean; one flip from a codeword -> single; else double.
  function automatic logic [19:0] model(input logic [15:0] c);
    logic [15:0] t;
    if (enc(ext(c)) == c) return {4'd0, 2'b00, 3'b000, ext(c)};
    for (int f = 0; f < 16; f++) begin
      t = c ^ (16'h0001 << f);
      if (enc(ext(t)) == t) return {4'(f), 2'b01, 3'b000, ext(t)};
    end
    return {4'd0, 2'b10, 3'b000, ext(c)};
  endfunction

  // Scoreboard: check outputs and counters, then log new accepts.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_sgl = 0;
      m_dbl = 0;
    end else begin
      chk("sgl_cnt_sb", sgl_cnt, m_sgl);
      chk("dbl_cnt_sb", dbl_cnt, m_dbl);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_word_sb", out_word, mon_e[15:0]);
`ifdef SECDED_ERR_POS_EN
          chk("out_pos_sb", out_pos, mon_e[19:16]);
`endif
          if (mon_e[14] && m_sgl < CNT_MAX) m_sgl++;
          if (mon_e[15] && m_dbl < CNT_MAX) m_dbl++;
        end
      end
      if (cnt_clr) begin
        m_sgl = 0;
        m_dbl = 0;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_code));
    end
  end

  task automatic send(input logic [15:0] c);
    bit acc;
    int t;
    in_valid = 1'b1;
    in_code  = c;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("send_timeout", in_ready, 1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !idle) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_idle", idle, 1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // One isolated word: checks 2-cycle latency, content and counters after its handshake.
  task automatic one_word(input logic [15:0] c, input logic [15:0] ew, input logic [3:0] ep,
                          input bit clr, input int es, input int ed);
    in_valid  = 1'b1;
    in_code   = c;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_s1", out_valid, 1'b0);
    @(posedge clk); #1;
    cnt_clr = clr;
    @(negedge clk);
    chk("lat_valid", out_valid, 1'b1);
    chk("word", out_word, ew);
`ifdef SECDED_ERR_POS_EN
    chk("pos", out_pos, ep);
`endif
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_sgl", sgl_cnt, es);
    chk("cnt_dbl", dbl_cnt, ed);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] base;
    logic [15:0] c;
    logic [10:0] d;
    int f1;
    int f2;

    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_word", out_word, 16'h0000);
    chk("rst_sgl", sgl_cnt, 0);
    chk("rst_dbl", dbl_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    one_word(16'hFFFF, 16'h07FF, 4'd0, 1'b0, 0, 0);
    one_word(16'h7FFF, 16'h47FF, 4'd15, 1'b0, 1, 0);
    one_word(16'h0020, 16'h4000, 4'd5, 1'b0, 2, 0);
    one_word(16'h0001, 16'h4000, 4'd0, 1'b0, 3, 0);
    one_word(16'h0220, 16'h8012, 4'd0, 1'b0, 3, 1);
    one_word(16'h0040, 16'h4000, 4'd6, 1'b0, 3, 1);
    one_word(16'h0080, 16'h4000, 4'd7, 1'b0, 3, 1);
    one_word(16'h0100, 16'h4000, 4'd8, 1'b1, 0, 0);

    // Sweep: every single-bit flip of one codeword, back-to-back.
    base = enc(11'h2A5);
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (cyc < 16) begin
        in_valid = 1'b1;
        in_code  = base ^ (16'h0001 << cyc);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc < 16) chk("sweep_in_ready", in_ready, 1'b1);
      if (cyc >= 2) begin
        chk("sweep_valid", out_valid, 1'b1);
        chk("sweep_word", out_word, 16'h42A5);
      end
      @(posedge clk); #1;
    end
    drain();

    // Backpressure: out_ready low for the first 3 cycles of a 4-word burst.
    fork
      begin
        for (int i = 0; i < 4; i++) send(enc(11'(i * 16'h0123 + 16'h0055)) ^ (16'h0001 << (i * 3)));
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = enc(11'h1A3);
    @(posedge clk); #1;
    in_code = enc(11'h05C) ^ 16'h0008;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_idle", idle, 1'b1);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    d = 11'($urandom_range(0, 2047));
    one_word(enc(d), {5'b00000, d}, 4'd0, 1'b0, 0, 0);

    // Randomized stream with random backpressure and occasional counter clears.
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          d  = 11'($urandom_range(0, 2047));
          c  = enc(d);
          f1 = $urandom_range(0, 15);
          f2 = (f1 + $urandom_range(1, 15)) % 16;
          case ($urandom_range(0, 3))
            0: c = c;
            1: c = c ^ (16'h0001 << f1);
            2: c = c ^ (16'h0001 << f1) ^ (16'h0001 << f2);
            default: c = 16'($urandom_range(0, 65535));
          endcase
          send(c);
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          cnt_clr   = ($urandom_range(0, 31) == 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
